// File: rtl/tcp_tx_layer_if.sv
// rtl/tcp_tx_layer_if.sv - segment word stream towards the IP transmit layer
interface tcp_tx_layer_if;
  logic        ip_rdy_i;
  logic        ip_op_st_o;
  logic        ip_op_o;
  logic        ip_op_end_o;
  logic [31:0] ip_data_o;
  logic [15:0] ip_data_len_o;
  logic [31:0] ip_dst_addr_o;
  logic [7:0]  ip_prot_o;

  modport master (
    input  ip_rdy_i,
    output ip_op_st_o, ip_op_o, ip_op_end_o, ip_data_o,
    output ip_data_len_o, ip_dst_addr_o, ip_prot_o
  );

  modport slave (
    output ip_rdy_i,
    input  ip_op_st_o, ip_op_o, ip_op_end_o, ip_data_o,
    input  ip_data_len_o, ip_dst_addr_o, ip_prot_o
  );
endinterface

// File: rtl/tcp_tx_layer.sv
// rtl/tcp_tx_layer.sv - TCP transmit segment builder
module tcp_tx_layer #(
  parameter int MAX_WORDS = 375,
  parameter int BUF_AW    = 9
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] src_ip_addr_i,
  input  logic [31:0] dst_ip_addr_i,
  input  logic        start_i,
  input  logic [15:0] source_port_i,
  input  logic [15:0] dest_port_i,
  input  logic [31:0] seq_num_i,
  input  logic [31:0] ack_num_i,
  input  logic [5:0]  tcp_flags_i,
  input  logic [15:0] tcp_window_i,
  input  logic [15:0] pay_len_i,
  input  logic        pay_op_i,
  input  logic [31:0] pay_data_i,
  output logic        busy_o,
  output logic        err_o,
  tcp_tx_layer_if.master ip
);
  typedef enum logic [2:0] {IDLE, LOAD, CSUM1, CSUM2, SEND} state_t;
  localparam logic [15:0] MAX_BYTES = 16'(4 * MAX_WORDS);

  state_t            state, state_nxt;
  logic [31:0]       src_ip, dst_ip, seq, ack;
  logic [15:0]       sport, dport, window, len, csum;
  logic [5:0]        flags;
  logic [BUF_AW-1:0] wcnt, rd_addr;
  logic [BUF_AW:0]   w, w_nxt;
  logic [31:0]       acc, hdr_sum, wr_data, rd_q, data_mux;
  logic [16:0]       fold1;
  logic [15:0]       fold2, last_idx, last_w, seg_len;
  logic              start_ok, wr_en, wr_last, send_last;
  logic [31:0]       mem [0:MAX_WORDS-1];

  assign start_ok  = (state == IDLE) && start_i && (pay_len_i <= MAX_BYTES);
  assign last_idx  = ((len + 16'd3) >> 2) - 16'd1;
  assign last_w    = ((len + 16'd3) >> 2) + 16'd4;
  assign seg_len   = len + 16'd20;
  assign wr_en     = (state == LOAD) && pay_op_i;
  assign wr_last   = (16'(wcnt) == last_idx);
  assign send_last = (16'(w) == last_w);
  assign busy_o    = (state != IDLE);

  // Tail bytes past len are zeroed so storage and checksum agree.
  always_comb begin
    wr_data = pay_data_i;
    if (wr_last) begin
      case (len[1:0])
        2'd1:    wr_data[23:0] = 24'h0;
        2'd2:    wr_data[15:0] = 16'h0;
        2'd3:    wr_data[7:0]  = 8'h0;
        default: ;
      endcase
    end
  end

  assign hdr_sum = {16'h0, src_ip[31:16]} + {16'h0, src_ip[15:0]}
                 + {16'h0, dst_ip[31:16]} + {16'h0, dst_ip[15:0]}
                 + 32'h6 + {16'h0, seg_len}
                 + {16'h0, sport} + {16'h0, dport}
                 + {16'h0, seq[31:16]} + {16'h0, seq[15:0]}
                 + {16'h0, ack[31:16]} + {16'h0, ack[15:0]}
                 + {16'h0, 4'd5, 6'b0, flags} + {16'h0, window};
  assign fold1 = {1'b0, acc[31:16]} + {1'b0, acc[15:0]};
  assign fold2 = fold1[15:0] + {15'h0, fold1[16]};

  always_comb begin
    state_nxt = state;
    w_nxt     = w;
    case (state)
      IDLE:  if (start_ok) state_nxt = (pay_len_i == 16'd0) ? CSUM1 : LOAD;
      LOAD:  if (wr_en && wr_last) state_nxt = CSUM1;
      CSUM1: state_nxt = CSUM2;
      CSUM2: begin
        state_nxt = SEND;
        w_nxt     = '0;
      end
      SEND: if (ip.ip_rdy_i) begin
        if (send_last) begin
          state_nxt = IDLE;
          w_nxt     = '0;
        end else begin
          w_nxt = w + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Read address follows the next word index so payload words arrive without bubbles.
  assign rd_addr = (state_nxt == SEND && w_nxt >= (BUF_AW+1)'(5))
                 ? BUF_AW'(w_nxt - (BUF_AW+1)'(5)) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      w      <= '0;
      wcnt   <= '0;
      acc    <= '0;
      csum   <= '0;
      err_o  <= 1'b0;
      src_ip <= '0;
      dst_ip <= '0;
      seq    <= '0;
      ack    <= '0;
      sport  <= '0;
      dport  <= '0;
      window <= '0;
      len    <= '0;
      flags  <= '0;
    end else begin
      state <= state_nxt;
      w     <= w_nxt;
      err_o <= (state == IDLE) && start_i && (pay_len_i > MAX_BYTES);
      if (start_ok) begin
        src_ip <= src_ip_addr_i;
        dst_ip <= dst_ip_addr_i;
        seq    <= seq_num_i;
        ack    <= ack_num_i;
        sport  <= source_port_i;
        dport  <= dest_port_i;
        window <= tcp_window_i;
        len    <= pay_len_i;
        flags  <= tcp_flags_i;
        acc    <= '0;
        wcnt   <= '0;
      end
      if (wr_en) begin
        wcnt <= wcnt + 1'b1;
        acc  <= acc + {16'h0, wr_data[31:16]} + {16'h0, wr_data[15:0]};
      end
      if (state == CSUM1) acc <= acc + hdr_sum;
      if (state == CSUM2) csum <= ~fold2;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wcnt] <= wr_data;
    rd_q <= mem[rd_addr];
  end

  always_comb begin
    data_mux = '0;
    if (state == SEND) begin
      case (w)
        (BUF_AW+1)'(0): data_mux = {sport, dport};
        (BUF_AW+1)'(1): data_mux = seq;
        (BUF_AW+1)'(2): data_mux = ack;
        (BUF_AW+1)'(3): data_mux = {4'd5, 6'b0, flags, window};
        (BUF_AW+1)'(4): data_mux = {csum, 16'h0000};
        default:        data_mux = rd_q;
      endcase
    end
  end

  assign ip.ip_op_o       = (state == SEND);
  assign ip.ip_op_st_o    = (state == SEND) && (w == '0);
  assign ip.ip_op_end_o   = (state == SEND) && send_last;
  assign ip.ip_data_o     = data_mux;
  assign ip.ip_data_len_o = busy_o ? seg_len : 16'h0;
  assign ip.ip_dst_addr_o = busy_o ? dst_ip : 32'h0;
  assign ip.ip_prot_o     = 8'd6;
endmodule

// File: tb/tb_tcp_tx_layer.sv
// tb/tb_tcp_tx_layer.sv - self-checking bench for tcp_tx_layer
module tb_tcp_tx_layer;
  localparam logic [31:0] SRC = 32'hC0A80001;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] dst_ip_addr_i = '0, seq_num_i = '0, ack_num_i = '0, pay_data_i = '0;
  logic        start_i = 1'b0, pay_op_i = 1'b0;
  logic [15:0] source_port_i = '0, dest_port_i = '0, tcp_window_i = '0, pay_len_i = '0;
  logic [5:0]  tcp_flags_i = '0;
  logic        busy_o, err_o;

  tcp_tx_layer_if ip();

  tcp_tx_layer dut (
    .clk(clk), .rst_n(rst_n), .src_ip_addr_i(SRC), .dst_ip_addr_i(dst_ip_addr_i),
    .start_i(start_i), .source_port_i(source_port_i), .dest_port_i(dest_port_i),
    .seq_num_i(seq_num_i), .ack_num_i(ack_num_i), .tcp_flags_i(tcp_flags_i),
    .tcp_window_i(tcp_window_i), .pay_len_i(pay_len_i), .pay_op_i(pay_op_i),
    .pay_data_i(pay_data_i), .busy_o(busy_o), .err_o(err_o), .ip(ip)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] sport, dport;
    logic [31:0] seq, ack;
    logic [5:0]  flags;
    logic [15:0] win, len;
    logic [31:0] p0, p1, dip;
    int          rdy_mode;
    bit          gaps, exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    bit          st, last;
    logic [15:0] seg_len;
    logic [31:0] dst;
  } exp_t;

  exp_t exp_q[$];
  vec_t vecs[7];
  int   checks = 0, errors = 0, popped = 0, rdy_mode = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [31:0] pay_raw(vec_t v, int k);
    if (k == 0) return v.p0;
    if (k == 1) return v.p1;
    return v.p0 ^ (32'(k) * 32'h9E3779B9);
  endfunction

  function automatic logic [31:0] pay_exp(vec_t v, int k);
    logic [31:0] d = pay_raw(v, k);
    for (int b = 0; b < 4; b++)
      if (4 * k + b >= int'(v.len)) d[31-8*b -: 8] = 8'h00;
    return d;
  endfunction

  function automatic logic [15:0] fold(logic [31:0] s);
    while (s[31:16] != 16'h0) s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
    return s[15:0];
  endfunction

  function automatic logic [31:0] halves(logic [31:0] d);
    return {16'h0, d[31:16]} + {16'h0, d[15:0]};
  endfunction

  function automatic logic [31:0] pseudo(logic [31:0] dst, logic [15:0] seg_len);
    return halves(SRC) + halves(dst) + 32'h6 + {16'h0, seg_len};
  endfunction

  task automatic push_expected(vec_t v);
    logic [31:0] w[5];
    logic [31:0] sum;
    int          n = (int'(v.len) + 3) / 4;
    exp_t        e;
    w[0] = {v.sport, v.dport};
    w[1] = v.seq;
    w[2] = v.ack;
    w[3] = {4'd5, 6'b0, v.flags, v.win};
    sum  = pseudo(v.dip, v.len + 16'd20) + halves(w[0]) + halves(w[1])
         + halves(w[2]) + halves(w[3]);
    for (int k = 0; k < n; k++) sum += halves(pay_exp(v, k));
    w[4] = {~fold(sum), 16'h0000};
    for (int i = 0; i < 5 + n; i++) begin
      e.data    = (i < 5) ? w[i] : pay_exp(v, i - 5);
      e.st      = (i == 0);
      e.last    = (i == 4 + n);
      e.seg_len = v.len + 16'd20;
      e.dst     = v.dip;
      exp_q.push_back(e);
    end
  endtask

  // Ready pattern: 0 = always, 1 = 1,0,0 repeating, 2 = random.
  initial begin
    int n = 0;
    ip.ip_rdy_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        1:       ip.ip_rdy_i = (n % 3 == 0);
        2:       ip.ip_rdy_i = 1'($urandom_range(0, 1));
        default: ip.ip_rdy_i = 1'b1;
      endcase
      n++;
    end
  end

  initial begin
    logic [31:0] vsum = '0, prev = '0;
    bit          stall = 1'b0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (stall) check("hold_data", {31'h0, ip.ip_op_o, ip.ip_data_o}, {32'h1, prev});
      stall = ip.ip_op_o && !ip.ip_rdy_i;
      prev  = ip.ip_data_o;
      if (ip.ip_op_o && ip.ip_rdy_i) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", ip.ip_op_o, 0);
        end else begin
          e = exp_q.pop_front();
          popped++;
          check("word_data", ip.ip_data_o, e.data);
          check("word_st", ip.ip_op_st_o, e.st);
          check("word_end", ip.ip_op_end_o, e.last);
          if (e.st) begin
            check("seg_len", ip.ip_data_len_o, e.seg_len);
            check("dst_addr", ip.ip_dst_addr_o, e.dst);
            vsum = pseudo(e.dst, e.seg_len);
          end
          vsum += halves(ip.ip_data_o);
          if (e.last) check("csum_verify", fold(vsum), 16'hFFFF);
        end
      end
    end
  end

  task automatic wait_idle();
    int t = 0;
    while ((exp_q.size() != 0 || busy_o) && t < 6000) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("drain_done", {busy_o, exp_q.size() != 0}, 2'b00);
    exp_q.delete();
  endtask

  // Called at posedge+1: drives start this cycle, then the payload.
  task automatic issue(vec_t v, bit wait_done);
    int n = (int'(v.len) + 3) / 4;
    dst_ip_addr_i = v.dip; seq_num_i = v.seq; ack_num_i = v.ack;
    source_port_i = v.sport; dest_port_i = v.dport; tcp_flags_i = v.flags;
    tcp_window_i = v.win; pay_len_i = v.len; rdy_mode = v.rdy_mode;
    start_i = 1'b1;
    if (!v.exp_err) push_expected(v);
    @(posedge clk);
    #1;
    start_i = 1'b0;
    if (v.exp_err) begin
      check("err_pulse", err_o, 1);
      check("err_busy", busy_o, 0);
      @(posedge clk);
      #1;
      check("err_one_cycle", err_o, 0);
      repeat (6) @(posedge clk);
      #1;
      check("err_no_segment", {busy_o, ip.ip_op_o}, 2'b00);
      return;
    end
    check("busy_after_start", busy_o, 1);
    for (int k = 0; k < n; k++) begin
      if (v.gaps) begin
        pay_op_i = 1'b0;
        @(posedge clk);
        #1;
      end
      pay_op_i = 1'b1;
      pay_data_i = pay_raw(v, k);
      @(posedge clk);
      #1;
    end
    pay_op_i = 1'b0;
    if (wait_done) wait_idle();
  endtask

  task automatic run_vec(vec_t v, bit wait_done);
    @(posedge clk);
    #1;
    issue(v, wait_done);
  endtask

  initial begin
    vec_t a;
    int   t, target;
    vecs[0] = '{16'h1234, 16'h0050, 32'h00000001, 32'h0, 6'b000010, 16'hFFFF, 16'd0,
                32'h0, 32'h0, 32'h0A000002, 0, 1'b0, 1'b0};
    vecs[1] = '{16'h1234, 16'h0050, 32'h00000002, 32'h11223344, 6'b011000, 16'h2000, 16'd6,
                32'hAABBCCDD, 32'hEEFF1122, 32'h0A000002, 0, 1'b0, 1'b0};
    vecs[2] = '{16'hC000, 16'h01BB, 32'h89ABCDEF, 32'h01020304, 6'b010000, 16'h0400, 16'd8,
                32'h01234567, 32'h89ABCDEF, 32'hC0A80164, 1, 1'b0, 1'b0};
    vecs[3] = '{16'h0001, 16'h0002, 32'h3, 32'h4, 6'b010000, 16'h0100, 16'd1501,
                32'h0, 32'h0, 32'h0A000003, 0, 1'b0, 1'b1};
    vecs[4] = '{16'hFFFF, 16'hFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 6'b111111, 16'hFFFF, 16'd1500,
                32'hFFFFFFFF, 32'h5A5AA5A5, 32'hFFFFFFFF, 2, 1'b0, 1'b0};
    vecs[5] = '{16'h4000, 16'h0016, 32'h00010000, 32'h7FFF0001, 6'b011000, 16'h8000, 16'd13,
                32'hCAFEBABE, 32'hDEADBEEF, 32'h08080808, 2, 1'b1, 1'b0};
    vecs[6] = '{16'h0050, 16'h1234, 32'h0000FFFF, 32'hFFFF0000, 6'b011001, 16'h0001, 16'd3,
                32'h12345678, 32'h0, 32'hAC100001, 1, 1'b1, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs", {ip.ip_op_o, ip.ip_op_st_o, ip.ip_op_end_o, busy_o, err_o}, 5'b0);
    check("rst_data", ip.ip_data_o, 0);
    check("rst_len_dst", {ip.ip_data_len_o, ip.ip_dst_addr_o}, 48'h0);
    check("rst_prot", ip.ip_prot_o, 8'd6);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) run_vec(vecs[i], 1'b1);

    // Back-to-back: second start in the cycle busy falls, stray pay_op during SEND.
    a = vecs[1];
    a.len = 16'd4;
    run_vec(a, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    pay_op_i = 1'b1;
    pay_data_i = 32'hDEADBEEF;
    @(posedge clk);
    #1;
    pay_op_i = 1'b0;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(ip.ip_op_o && ip.ip_rdy_i && ip.ip_op_end_o) && t < 200);
    check("b2b_last_seen", ip.ip_op_end_o, 1);
    @(posedge clk);
    #1;
    check("b2b_busy_fell", busy_o, 0);
    issue(vecs[5], 1'b1);

    // Reset after w2 has been accepted.
    a = vecs[2];
    a.rdy_mode = 0;
    target = popped + 3;
    run_vec(a, 1'b0);
    t = 0;
    while (popped < target && t < 200) begin
      @(posedge clk);
      t++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_send_op", {ip.ip_op_o, ip.ip_op_st_o, ip.ip_op_end_o, busy_o}, 4'b0);
    check("rst_mid_send_data", {ip.ip_data_o, ip.ip_data_len_o}, 48'h0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_vec(vecs[1], 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end
endmodule
